// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit: eight two-operand functions, DEPTH registered stages,
// enable/ready input and valid/ready output with bubble-collapsing backpressure.
module logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             in_ready,
    output logic [WIDTH-1:0] z,
    output logic             z_valid,
    input  logic             out_ready,
    output logic             z_zero,
    output logic [15:0]      xfer_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0]            r_zf;
    logic [15:0]                 r_cnt;
    logic [WIDTH-1:0]            w_res;
    logic [DEPTH-1:0]            w_nv;
    logic [DEPTH-1:0]            w_adv;

    always_comb begin
        w_res = '0;
        case (op)
            3'b000:  w_res = a & b;
            3'b001:  w_res = a | b;
            3'b010:  w_res = a ^ b;
            3'b011:  w_res = ~(a & b);
            3'b100:  w_res = ~(a | b);
            3'b101:  w_res = ~(a ^ b);
            3'b110:  w_res = a;
            default: w_res = b;
        endcase
    end

    // Stage i may advance if the consumer is ready or any stage from i upward is empty.
    assign w_nv = ~r_v;
    for (genvar g = 0; g < DEPTH; g++) begin : g_adv
        assign w_adv[g] = out_ready || (|(w_nv >> g));
    end

    assign in_ready = w_adv[0] && !rst_n;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v    <= '0;
            r_zf   <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_adv[0]) begin
                r_v[0]  <= en;
                r_zf[0] <= en && (w_res == '0);
                if (en)
                    r_data[0] <= w_res;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_v[i]    <= r_v[i-1];
                    r_zf[i]   <= r_zf[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
            if (r_v[DEPTH-1] && out_ready)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    // The zero flag travels with its entry, so it is already gated by valid.
    assign z        = r_data[DEPTH-1];
    assign z_valid  = r_v[DEPTH-1];
    assign z_zero   = r_zf[DEPTH-1];
    assign xfer_cnt = r_cnt;

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit: two WIDTH-bit operands and a 3-bit opcode enter under an enable/ready handshake, pass through DEPTH registered stages, and leave on a valid/ready output with a transfer counter. It is the multi-bit, multi-function, back-pressurable generation of the single-bit enabled logic cell. It sits between an operand source and any consumer that can stall.

## Interface
- WIDTH, 8: operand and result width in bits, ≥1.
- DEPTH, 2: number of pipeline stages, ≥1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset; the name is kept for codebase compatibility, and asserted means rst_n=1.
- en  input  1  input valid; the operand/op set is transferred on a rising edge where en && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  function select, sampled with a/b.
- in_ready  output  1  the pipeline can accept a transfer this cycle.
- z  output  WIDTH  registered result.
- z_valid  output  1  z holds a result not yet consumed.
- out_ready  input  1  consumer accepts z this cycle.
- z_zero  output  1  registered; z == 0 while z_valid=1, otherwise 0.
- xfer_cnt  output  16  count of completed output transfers (z_valid && out_ready), wraps 0xFFFF→0x0000.

## Operation
- op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 pass A, 111 pass B.
  - The operation is bitwise over WIDTH bits. There is no carry and no width growth.
- The result is computed combinationally from a/b/op and loaded into stage 0 on the accepting edge. Stages 1..DEPTH-1 are pure delay. The last stage drives z/z_valid/z_zero.
- Each stage holds a valid bit v[i] and WIDTH data bits.
- Advance rule:
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1].
  - Stage i+1 loads stage i when adv[i+1]. v[i+1] takes v[i].
  - A stage that passes its entry on without receiving one clears its valid bit.
- in_ready = adv[0] && !rst_n. The combinational path from out_ready to in_ready is intentional and bubble-collapsing.
- Stage 0 loads the new result with v[0]=1 on en && in_ready. If adv[0] holds and en=0, v[0] clears.
- Backpressure: while z_valid && !out_ready, z, z_zero and z_valid hold stable.
  - Upstream stages keep filling until all DEPTH stages are valid.
  - Once all stages are valid, in_ready=0.
  - Entries are never dropped, duplicated or reordered.
- xfer_cnt increments by 1 on every edge with z_valid && out_ready. Wrap-around is silent.
- Reset, asynchronous on rst_n rising:
  - Every v[i]=0 and all data=0.
  - z=0, z_valid=0, z_zero=0, xfer_cnt=0.
  - in_ready=0 while reset is held.
  - In-flight entries are discarded; none emerge after release.
  - After release, in_ready=1 in the first cycle.
- en=1 while in_ready=0 has no effect. The source must hold its data until accepted.

## Timing
- Latency: a transfer accepted at edge N appears on z/z_valid after edge N+DEPTH-1. For DEPTH=1 the accepting edge loads z directly.
- Throughput: one result per cycle while out_ready=1 and en=1.
- Simultaneous events:
  - Full pipeline plus out_ready=1 plus en=1: in the same cycle the last stage is consumed, everything shifts, and the new entry enters stage 0. Occupancy stays DEPTH.
  - Output transfer and reset on the same edge: reset wins and xfer_cnt=0.
- No output depends combinationally on a, b or op.

## Test plan
- Reset:
  - Stimulus: rst_n=1 mid-stream with 2 entries in flight (DEPTH=2).
  - Required: z=0, z_valid=0, z_zero=0, xfer_cnt=0 and in_ready=0 immediately (asynchronous).
  - After release: in_ready=1 and no stale result ever appears.
- All ops:
  - Setup: WIDTH=8, DEPTH=2, out_ready=1, a=0xF0, b=0xCC.
  - Ops 000..111 must give z = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0xF0, 0xCC in order, one per cycle.
  - Each result appears 1 edge after acceptance.
  - z_zero=1 only for a=0x0F, b=0xF0, op=000.
- Enable gating:
  - Stimulus: en=0 with changing a/b/op for 5 cycles.
  - Required: z_valid stays 0 and xfer_cnt is unchanged.
- Backpressure:
  - Stimulus: out_ready=0 while 3 entries are offered (DEPTH=2).
  - Required: in_ready drops after 2 acceptances and z holds the first result.
  - Then out_ready=1: results emerge in order, the 3rd entry is accepted in the same cycle space frees, and xfer_cnt rises by 3.
- Counter wrap: forced or long run with xfer_cnt=0xFFFF; one more transfer gives 0x0000.
- DEPTH=1 and WIDTH=1 build:
  - Stimulus: a=1, b=1 under op XOR, then NAND, then OR.
  - Required: z=0, 0, 1 on consecutive cycles, each visible right after its accepting edge.
